fc_argmax_reporter: RTL and testbench
=====================================

Name: fc_argmax_reporter

Overview:
- Sink at the far end of the fully-connected layer.
- Accepts the CLASSIFICATIONS signed class scores serially through a valid/ready handshake and tracks the running maximum.
- Once the set is complete, presents the winning class as a one-hot led vector and raises done.
- Top-level result reporter: drives the led/done outputs the CNN bench reads.

Parameters:
- CLASSIFICATIONS, 10, number of scores per image.
- FC_RESULT_DEPTH, 30, width of each signed two's-complement score.
- IDX_WIDTH, 4, width of the class index; must satisfy 2**IDX_WIDTH >= CLASSIFICATIONS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a new score set.
- score_in  input  FC_RESULT_DEPTH  signed class score; index is implied by arrival order.
- score_valid  input  1  score_in is valid this cycle.
- score_last  input  1  marks the final score of a set; qualified by score_valid.
- score_ready  output  1  block accepts a score this cycle.
- led  output  CLASSIFICATIONS  one-hot winning class; all zero when not done or on error.
- class_idx  output  IDX_WIDTH  index of the winning class.
- max_score  output  FC_RESULT_DEPTH  winning score.
- done  output  1  result valid; held until the next start.
- busy  output  1  collecting scores.
- err  output  1  framing error on the last completed set.

Behaviour:
- Reset (async, rst=1): state=IDLE, count=0, and score_ready, led, class_idx, max_score, done, busy, err all 0.
- State machine:
  - IDLE to COLLECT on start=1.
  - COLLECT to DONE on the final handshake or on a framing error.
  - DONE to COLLECT on start=1.
- start clears count, class_idx, max_score, led, done and err on the same edge.
- start is ignored while in COLLECT.
- score_ready=1 only in COLLECT; it is a registered function of state.
- busy=1 exactly in COLLECT.
- Handshake: a score is accepted on a rising edge where score_valid&score_ready=1. score_in and score_last are sampled only then.
- score_valid while score_ready=0 is ignored; nothing is captured.
- Compare rule:
  - The first accepted score (count==0) always loads max_score and sets class_idx=0.
  - Each later score replaces the max only if strictly greater (signed compare); class_idx then takes count.
  - Ties keep the lower index.
- count increments on each accepted score.
- Normal completion: the accepted score with count==CLASSIFICATIONS-1 and score_last=1 moves the FSM to DONE on that same edge.
  - done=1, led=1<<class_idx (final comparison included) and err=0 are registered on that edge.
  - Latency: results are visible the cycle after the final handshake.
- Framing errors:
  - Early last: score_last=1 with count<CLASSIFICATIONS-1.
  - Missing last: score_last=0 with count==CLASSIFICATIONS-1.
  - In either case, on that edge: DONE, done=1, err=1, led=0. class_idx and max_score hold the partial result including that score.
- In DONE, score_ready=0; further scores are not accepted and outputs hold stable.
- start coincident with score_valid in IDLE/DONE: start wins and no score is accepted that cycle, since score_ready is still 0.
- Reset mid-set: immediate return to IDLE with all outputs 0; the partial set is discarded.
- Widths:
  - Comparison is full-width signed; no saturation or truncation.
  - count is IDX_WIDTH bits and never wraps, because the FSM leaves COLLECT at CLASSIFICATIONS-1.
- led is all zero except for exactly one bit in a successful DONE.

Test Plan:
- Reset: assert rst mid-simulation without a clock edge -> all outputs 0 immediately; score_ready=0 in IDLE.
- Basic: start, then scores 5,-3,12,7,0,12,-100,2,11,4 (last on the 10th), back-to-back valid -> the cycle after the 10th handshake: done=1, class_idx=2 (tie at 5 keeps 2), max_score=12, led=10'b0000000100, err=0, busy=0.
- Negative and stall: scores all negative, -50,-9,-9,-200,... with the max -1 at index 9; score_valid toggled with idle gaps -> class_idx=9, led=10'b1000000000, max_score=-1. Gaps do not advance count.
- Signed extremes: score 0x1FFFFFFF (max positive) at index 4, and 0x20000000 (most negative) elsewhere -> class_idx=4. Most-negative never wins over any other value.
- Framing errors:
  - score_last on the 6th score -> the next cycle has done=1, err=1, led=0, with no 7th handshake accepted.
  - Separate run with no score_last on the 10th -> err=1.
- Restart and mid-op reset:
  - In DONE, pulse start -> done/led/err clear the next cycle, busy=1, and a new set is processed correctly.
  - Assert rst after 4 scores -> IDLE. A fresh start plus 10 scores gives the correct result, unaffected by the discarded partial set.

Source files
------------

// File: rtl/fc_argmax_reporter.sv
// fc_argmax_reporter: collects a set of signed class scores over a valid/ready
// handshake, tracks the running maximum, and reports the winning class as a
// one-hot led vector with done/err status once the set is framed.
module fc_argmax_reporter #(
  parameter int unsigned CLASSIFICATIONS = 10,
  parameter int unsigned FC_RESULT_DEPTH = 30,
  parameter int unsigned IDX_WIDTH       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [FC_RESULT_DEPTH-1:0] score_in,
  input  logic                       score_valid,
  input  logic                       score_last,
  output logic                       score_ready,
  output logic [CLASSIFICATIONS-1:0] led,
  output logic [IDX_WIDTH-1:0]       class_idx,
  output logic [FC_RESULT_DEPTH-1:0] max_score,
  output logic                       done,
  output logic                       busy,
  output logic                       err
);

  localparam int unsigned LAST_IDX = CLASSIFICATIONS - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                     state, state_nxt;
  logic [IDX_WIDTH-1:0]       count, count_nxt;
  logic [IDX_WIDTH-1:0]       class_idx_nxt;
  logic [FC_RESULT_DEPTH-1:0] max_score_nxt;
  logic [CLASSIFICATIONS-1:0] led_nxt;
  logic                       done_nxt;
  logic                       err_nxt;
  logic                       ready_nxt;
  logic                       busy_nxt;
  logic                       accept;
  logic                       at_last_pos;
  logic                       take_new;

  // State register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      class_idx   <= '0;
      max_score   <= '0;
      led         <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      score_ready <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      class_idx   <= class_idx_nxt;
      max_score   <= max_score_nxt;
      led         <= led_nxt;
      done        <= done_nxt;
      err         <= err_nxt;
      score_ready <= ready_nxt;
      busy        <= busy_nxt;
    end
  end

  // Next-state, running-max update and framing checks.
  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    class_idx_nxt = class_idx;
    max_score_nxt = max_score;
    led_nxt       = led;
    done_nxt      = done;
    err_nxt       = err;
    accept        = score_valid & score_ready;
    at_last_pos   = (count == IDX_WIDTH'(LAST_IDX));
    take_new      = (count == '0) || ($signed(score_in) > $signed(max_score));

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt     = COLLECT;
          count_nxt     = '0;
          class_idx_nxt = '0;
          max_score_nxt = '0;
          led_nxt       = '0;
          done_nxt      = 1'b0;
          err_nxt       = 1'b0;
        end
      end
      COLLECT: begin
        if (accept) begin
          // Strictly-greater update so ties keep the lower index.
          if (take_new) begin
            max_score_nxt = score_in;
            class_idx_nxt = count;
          end
          count_nxt = count + IDX_WIDTH'(1);
          if (score_last && at_last_pos) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            err_nxt   = 1'b0;
            led_nxt   = CLASSIFICATIONS'(1) << class_idx_nxt;
          end else if (score_last != at_last_pos) begin
            // Early or missing last: report error, keep the partial max.
            state_nxt = DONE;
            done_nxt  = 1'b1;
            err_nxt   = 1'b1;
            led_nxt   = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    ready_nxt = (state_nxt == COLLECT);
    busy_nxt  = (state_nxt == COLLECT);
  end

endmodule

// File: tb/tb_fc_argmax_reporter.sv
// Testbench for fc_argmax_reporter: directed and randomized score sets checked
// against an array-based argmax/framing reference model.
module tb_fc_argmax_reporter;

  localparam int unsigned C  = 10;
  localparam int unsigned W  = 30;
  localparam int unsigned IW = 4;
  localparam int unsigned VW = 4 + C + IW + W;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  score_in;
  logic          score_valid;
  logic          score_last;
  logic          score_ready;
  logic [C-1:0]  led;
  logic [IW-1:0] class_idx;
  logic [W-1:0]  max_score;
  logic          done;
  logic          busy;
  logic          err;

  int checks = 0;
  int errors = 0;

  logic signed [W-1:0] sc [C];
  bit                  lst[C];

  logic [VW-1:0] obs;
  logic [VW-1:0] expv;
  assign obs = {done, err, busy, score_ready, led, class_idx, max_score};

  fc_argmax_reporter #(
    .CLASSIFICATIONS(C),
    .FC_RESULT_DEPTH(W),
    .IDX_WIDTH(IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .score_in(score_in),
    .score_valid(score_valid),
    .score_last(score_last),
    .score_ready(score_ready),
    .led(led),
    .class_idx(class_idx),
    .max_score(max_score),
    .done(done),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  // Position of the score that ends the set: first flagged last, else the final slot.
  function automatic int end_idx();
    int e = C - 1;
    bit found = 0;
    for (int i = 0; i < C; i++) begin
      if (lst[i] && !found) begin
        e = i;
        found = 1;
      end
    end
    return e;
  endfunction

  // Expected outputs once the set stored in sc/lst has been consumed.
  function automatic logic [VW-1:0] model_vec();
    int e = end_idx();
    int bi = 0;
    logic signed [W-1:0] best = sc[0];
    bit er;
    logic [C-1:0] l;
    for (int i = 1; i <= e; i++) begin
      if (sc[i] > best) begin
        best = sc[i];
        bi = i;
      end
    end
    er = !(e == C - 1 && lst[e]);
    l = er ? '0 : (C'(1) << bi);
    return {1'b1, er, 1'b0, 1'b0, l, IW'(bi), best};
  endfunction

  task automatic clear_set();
    for (int i = 0; i < C; i++) begin
      sc[i] = '0;
      lst[i] = 0;
    end
  endtask

  task automatic rand_scores(input bit narrow);
    for (int i = 0; i < C; i++) begin
      if (narrow) sc[i] = W'(int'($urandom_range(0, 6)) - 3);
      else        sc[i] = W'($urandom());
    end
  endtask

  // Offer n scores from sc/lst, optionally preceded by a start pulse that
  // coincides with a decoy valid score. Random idle gaps carry decoy data.
  task automatic send_set(input bit do_start, input int n, input int gap_pct);
    if (do_start) begin
      @(negedge clk);
      start = 1'b1;
      score_valid = 1'b1;
      score_in = W'(30'h1FFFFFFF);
      score_last = 1'b1;
      @(negedge clk);
      start = 1'b0;
      score_valid = 1'b0;
      score_last = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      int t = 0;
      @(negedge clk);
      if (int'($urandom_range(0, 99)) < gap_pct) begin
        score_valid = 1'b0;
        score_in = W'(30'h1FFFFFFF);
        score_last = 1'b1;
        @(negedge clk);
      end
      score_valid = 1'b1;
      score_in = sc[i];
      score_last = lst[i];
      while (!score_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!score_ready) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout score=%0d ready=%b required=1", i, score_ready);
        score_valid = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    score_valid = 1'b0;
    score_last = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_hold got=%h required=%h", obs, VW'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL idle_after_reset got=%h required=%h", obs, VW'(0));
    end
  endtask

  task automatic test_basic();
    int v[C] = '{5, -3, 12, 7, 0, 12, -100, 2, 11, 4};
    clear_set();
    for (int i = 0; i < C; i++) sc[i] = W'(v[i]);
    lst[C-1] = 1;
    send_set(1, C, 0);
    expv = {1'b1, 1'b0, 1'b0, 1'b0, C'(10'b0000000100), IW'(2), W'(12)};
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL basic got=%h required=%h", obs, expv);
    end
    checks++;
    if (model_vec() !== expv) begin
      errors++;
      $display("FAIL basic_model got=%h required=%h", model_vec(), expv);
    end
  endtask

  task automatic test_negative_stall();
    int v[C] = '{-50, -9, -9, -200, -7, -30, -8, -1000, -2, -1};
    clear_set();
    for (int i = 0; i < C; i++) sc[i] = W'(v[i]);
    lst[C-1] = 1;
    send_set(1, C, 60);
    expv = model_vec();
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL negative_stall got=%h required=%h", obs, expv);
    end
  endtask

  task automatic test_extremes();
    clear_set();
    for (int i = 0; i < C; i++) sc[i] = W'(30'h20000000);
    sc[4] = W'(30'h1FFFFFFF);
    lst[C-1] = 1;
    send_set(1, C, 0);
    expv = {1'b1, 1'b0, 1'b0, 1'b0, C'(10'b0000010000), IW'(4), W'(30'h1FFFFFFF)};
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL extreme_max got=%h required=%h", obs, expv);
    end
    for (int i = 0; i < C; i++) sc[i] = W'(30'h20000000);
    sc[7] = W'(-1);
    send_set(1, C, 0);
    expv = model_vec();
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL extreme_min got=%h required=%h", obs, expv);
    end
  endtask

  task automatic test_early_last();
    clear_set();
    rand_scores(0);
    lst[5] = 1;
    send_set(1, 6, 20);
    expv = model_vec();
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL early_last got=%h required=%h", obs, expv);
    end
    // Further valid scores must be refused and outputs held.
    score_valid = 1'b1;
    score_in = W'(30'h1FFFFFFF);
    score_last = 1'b1;
    repeat (3) @(negedge clk);
    score_valid = 1'b0;
    score_last = 1'b0;
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL done_hold got=%h required=%h", obs, expv);
    end
  endtask

  task automatic test_missing_last();
    clear_set();
    rand_scores(1);
    send_set(1, C, 20);
    expv = model_vec();
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL missing_last got=%h required=%h", obs, expv);
    end
  endtask

  task automatic test_restart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    expv = {1'b0, 1'b0, 1'b1, 1'b1, C'(0), IW'(0), W'(0)};
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL restart_clear got=%h required=%h", obs, expv);
    end
    clear_set();
    rand_scores(0);
    lst[C-1] = 1;
    send_set(0, C, 30);
    expv = model_vec();
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL restart_set got=%h required=%h", obs, expv);
    end
  endtask

  task automatic test_mid_reset();
    clear_set();
    for (int i = 0; i < 4; i++) sc[i] = W'(30'h1FFFFFFF);
    send_set(1, 4, 0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL mid_reset got=%h required=%h", obs, VW'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    clear_set();
    rand_scores(1);
    lst[C-1] = 1;
    send_set(1, C, 0);
    expv = model_vec();
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL after_mid_reset got=%h required=%h", obs, expv);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      int mode = int'($urandom_range(0, 3));
      clear_set();
      rand_scores(r % 2 == 1);
      if (mode == 0)      lst[$urandom_range(0, C - 2)] = 1;
      else if (mode != 1) lst[C-1] = 1;
      send_set(1, end_idx() + 1, 25);
      expv = model_vec();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL random_%0d got=%h required=%h", r, obs, expv);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    score_in = '0;
    score_valid = 1'b0;
    score_last = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_negative_stall();
    test_extremes();
    test_early_last();
    test_missing_last();
    test_restart();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
